nibble_sub16: RTL and testbench

NIBBLE_SUB16 -- requirements
Module: nibble_sub16

---
 rtl/nibble_sub16.sv | 102 ++++++++++
 tb/tb_nibble_sub16.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/nibble_sub16.sv
// Multi-cycle 16-bit subtractor: one 4-bit carry-lookahead slice per RUN cycle,
// LSB slice first, with borrow/zero/negative/overflow flags registered on completion.
module nibble_sub16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] Diff,
  output logic        Bout,
  output logic        Zero,
  output logic        Neg,
  output logic        Ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [1:0]  idx;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic        brw;

  logic [3:0]  sa;
  logic [3:0]  sb;
  logic [3:0]  g;
  logic [3:0]  p;
  logic [4:0]  c;
  logic [3:0]  sdiff;
  logic [15:0] diff_nxt;
  logic        bout_nxt;

  // Subtraction as A + ~B + ~borrow; carry-out is the inverse of the slice borrow.
  always_comb begin
    sa       = a_q[{idx, 2'b00} +: 4];
    sb       = ~b_q[{idx, 2'b00} +: 4];
    g        = sa & sb;
    p        = sa ^ sb;
    c[0]     = ~brw;
    c[1]     = g[0] | (p[0] & c[0]);
    c[2]     = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3]     = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4]     = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c[0]);
    sdiff    = p ^ c[3:0];
    bout_nxt = ~c[4];
    diff_nxt = Diff;
    diff_nxt[{idx, 2'b00} +: 4] = sdiff;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      brw   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      Diff  <= '0;
      Bout  <= 1'b0;
      Zero  <= 1'b0;
      Neg   <= 1'b0;
      Ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= A;
            b_q   <= B;
            brw   <= Bin;
            idx   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          Diff <= diff_nxt;
          brw  <= bout_nxt;
          idx  <= idx + 2'd1;
          if (idx == 2'd3) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            Bout  <= bout_nxt;
            Zero  <= (diff_nxt == '0);
            Neg   <= diff_nxt[15];
            Ovf   <= (a_q[15] ^ b_q[15]) & (diff_nxt[15] ^ a_q[15]);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_sub16.sv
// Scoreboard bench for nibble_sub16: expected results are queued at start
// acceptance and checked, including completion cycle, whenever done is seen.
module tb_nibble_sub16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        Bin;
  logic        busy;
  logic        done;
  logic [15:0] Diff;
  logic        Bout;
  logic        Zero;
  logic        Neg;
  logic        Ovf;

  nibble_sub16 dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .Bin  (Bin),
    .busy (busy),
    .done (done),
    .Diff (Diff),
    .Bout (Bout),
    .Zero (Zero),
    .Neg  (Neg),
    .Ovf  (Ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] diff;
    logic        bout;
    logic        zero;
    logic        neg;
    logic        ovf;
    int unsigned due;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned edges = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;

  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one start pulse; returns #1 after the accepting edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                          input bit track);
    logic [16:0] full;
    exp_t        e;
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (track) begin
      full   = {1'b0, a} - {1'b0, b} - {16'd0, bin};
      e.diff = full[15:0];
      e.bout = full[16];
      e.zero = (full[15:0] == 16'h0000);
      e.neg  = full[15];
      e.ovf  = (a[15] != b[15]) && (full[15] != a[15]);
      e.due  = edges + 4;
      sb_q.push_back(e);
    end
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) check("drain_timeout", sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", {31'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("done_cycle", edges, e.due);
        check("diff", {16'd0, Diff}, {16'd0, e.diff});
        check("bout", {31'd0, Bout}, {31'd0, e.bout});
        check("zero", {31'd0, Zero}, {31'd0, e.zero});
        check("neg",  {31'd0, Neg},  {31'd0, e.neg});
        check("ovf",  {31'd0, Ovf},  {31'd0, e.ovf});
        check("busy_in_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_flags", {27'd0, Diff == 16'h0, Bout, Zero, Neg, Ovf}, {27'd0, 1'b1, 4'b0000});
    rst = 1'b0;
    @(posedge clk); #1;

    start_op(16'h0003, 16'h0001, 1'b0, 1'b1); drain();
    start_op(16'h0000, 16'h0001, 1'b0, 1'b1); drain();
    start_op(16'h8000, 16'h0001, 1'b0, 1'b1); drain();
    start_op(16'h1234, 16'h1233, 1'b1, 1'b1); drain();

    // Back-to-back: second start lands in the DONE cycle of the first.
    start_op(16'h1000, 16'h0001, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    check("done_before_b2b", {31'd0, done}, 32'd1);
    start_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    drain();

    // Start while running (idx=1) is ignored.
    start_op(16'h5555, 16'h1111, 1'b0, 1'b1);
    @(posedge clk); #1;
    A = 16'h0F0F; B = 16'hAAAA; Bin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drain();
    check("idle_hold_diff", {16'd0, Diff}, 32'h4444);

    // Reset mid-run (idx=2) aborts without a done pulse.
    start_op(16'h7777, 16'h0123, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_flags", {27'd0, Diff == 16'h0, Bout, Zero, Neg, Ovf}, {27'd0, 1'b1, 4'b0000});
    repeat (6) @(posedge clk);
    #1;
    start_op(16'hABCD, 16'h1234, 1'b0, 1'b1); drain();

    for (int i = 0; i < 8; i++) begin
      start_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
